leg_branch_unit: RTL
====================

# leg_branch_unit

Program-counter and control-flow stage of the LEG core, directly downstream of the condition evaluator. Each cycle it takes the current instruction's opcode, the evaluator's one-bit condition result and the 8-bit branch target, then computes the next PC. Supported next-PC sources are sequential advance, taken conditional branch, CALL with return-address push, and RET with pop. It owns the hardware return stack and a sticky fault flag that halts the PC on stack misuse.

## Interface
Parameters:
- STACK_DEPTH, 8: number of return-address entries; must be ≥2.
- RESET_PC, 8'h00: PC value loaded on reset.
- PC_STEP, 8'd4: sequential increment; one LEG instruction is 4 bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  instruction valid/advance; when low, all state holds.
- opcode  in  8  current instruction byte 0; bits [7:6] are immediate flags and are ignored here, bits [5:0] decode.
- cond_true  in  1  condition result from the condition evaluator for this instruction.
- target  in  8  branch/call destination byte.
- pc  out  8  current program counter (registered).
- redirect  out  1  registered one-cycle pulse: the last accepted instruction changed flow (fetch discards).
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  out  1  sp == STACK_DEPTH.
- stack_empty  out  1  sp == 0.
- fault  out  1  sticky; stack overflow or underflow occurred; PC frozen.

## Operation
- Decode on op = opcode[5:0]:
  - COND: op in 6'h20..6'h25.
  - CALL: op == 6'h26.
  - RET: op == 6'h27.
  - All other values are SEQ.
- seq_pc = pc + PC_STEP, modulo 256. 8'hFC wraps to 8'h00 silently; this is not a fault.
- Accepted cycle (en=1, fault=0, rst=0):
  - SEQ: pc←seq_pc; redirect←0.
  - COND, cond_true=1: pc←target; redirect←1.
  - COND, cond_true=0: pc←seq_pc; redirect←0.
  - CALL, stack not full: stack[sp]←seq_pc; sp←sp+1; pc←target; redirect←1. cond_true is ignored.
  - CALL, stack full: fault←1; pc, sp and stack unchanged; redirect←0.
  - RET, stack not empty: pc←stack[sp-1]; sp←sp-1; redirect←1.
  - RET, stack empty: fault←1; pc and sp unchanged; redirect←0.
- en=0: pc, sp, stack and fault hold; redirect←0.
- fault=1: en is ignored and all state holds until rst. Only rst clears fault.
- A taken branch with target == seq_pc still asserts redirect. The unit does not compare addresses.
- Stack is a LIFO register array. Entries at or above sp are don't-care and are never read.
- stack_full and stack_empty are combinational decodes of registered sp.

## Timing
- Reset (rst=1 at an edge, overriding en): pc=RESET_PC, sp=0, redirect=0, fault=0, stack_empty=1, stack_full=0. Stack contents are not cleared.
- Reset mid-sequence discards any in-flight CALL/RET. Post-reset behaviour equals a power-up.
- Latency: inputs sampled at edge N; pc, sp, redirect and fault are valid after edge N. pc has no combinational path from any input.
- Throughput: one instruction per en cycle. Back-to-back CALL/RET are supported.
- A CALL then an immediate RET returns to the CALL's seq_pc.
- A RET then a CALL in consecutive cycles reuses the freed slot correctly.
- redirect is high for exactly one cycle per taken transfer. Consecutive taken transfers keep it high on consecutive cycles.
- fault rises on the edge that samples the offending instruction and stays high.

## Test plan
- Reset then 3 SEQ cycles (opcode 8'h00) → pc = 00, 04, 08, 0C; redirect stays 0. Start at pc=FC, SEQ → pc=00, fault=0.
- COND 8'h22 with target 8'h40: cond_true=1 → pc=40, redirect pulses 1 cycle. Repeat with cond_true=0 → pc=prev+4, redirect=0. Opcode 8'hE2 behaves identically to 8'h22.
- CALL 8'h26 at pc=10, target=80 → pc=80, sp=1. Then RET 8'h27 → pc=14, sp=0, stack_empty=1.
- Nested CALLs up to STACK_DEPTH=8 → stack_full=1. A 9th CALL → fault=1; pc, sp=8 and redirect=0 hold. Further en cycles change nothing until rst, then pc=RESET_PC, sp=0, fault=0.
- RET with sp=0 → fault=1, pc unchanged. en=0 for 5 cycles in normal mode → pc and sp hold, redirect=0.
- Assert rst in the same cycle as a CALL with sp=3 → pc=RESET_PC, sp=0, no push observed. A following RET faults.

Source files
------------

// File: rtl/leg_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : leg_branch_unit
// Description : LEG next-PC selection with hardware return stack and a
//               sticky stack-fault flag that freezes the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module leg_branch_unit #(
    parameter int          STACK_DEPTH = 8,
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [7:0]  PC_STEP     = 8'd4,
    localparam int         SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [7:0]      opcode,
    input  logic            cond_true,
    input  logic [7:0]      target,
    output logic [7:0]      pc,
    output logic            redirect,
    output logic [SP_W-1:0] sp,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            fault
);

    localparam int              IDX_W  = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] c_full = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] c_one  = SP_W'(1);

    logic [7:0]       r_pc;
    logic [SP_W-1:0]  r_sp;
    logic             r_redirect;
    logic             r_fault;
    logic [7:0]       r_stack [STACK_DEPTH];

    logic [5:0]       w_op;
    logic             w_is_cond;
    logic             w_is_call;
    logic             w_is_ret;
    logic [7:0]       w_seq_pc;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic [SP_W-1:0]  w_sp_dec;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_pop_idx;
    logic             w_unused_flags;

    // Immediate-flag bits are decoded elsewhere in the pipeline.
    assign w_unused_flags = &opcode[7:6];

    assign w_op       = opcode[5:0];
    assign w_is_cond  = (w_op >= 6'h20) && (w_op <= 6'h25);
    assign w_is_call  = (w_op == 6'h26);
    assign w_is_ret   = (w_op == 6'h27);
    assign w_seq_pc   = r_pc + PC_STEP;
    assign w_full     = (r_sp == c_full);
    assign w_empty    = (r_sp == '0);
    assign w_accept   = en && !r_fault;
    assign w_sp_dec   = r_sp - c_one;
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_pop_idx  = w_sp_dec[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_sp       <= '0;
            r_redirect <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            if (w_accept) begin
                if (w_is_call) begin
                    if (w_full) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_sp       <= r_sp + c_one;
                        r_pc       <= target;
                        r_redirect <= 1'b1;
                    end
                end else if (w_is_ret) begin
                    if (w_empty) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_sp       <= w_sp_dec;
                        r_pc       <= r_stack[w_pop_idx];
                        r_redirect <= 1'b1;
                    end
                end else if (w_is_cond && cond_true) begin
                    r_pc       <= target;
                    r_redirect <= 1'b1;
                end else begin
                    r_pc <= w_seq_pc;
                end
            end
        end
    end

    // Stack storage is deliberately not reset; entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && w_is_call && !w_full) begin
            r_stack[w_push_idx] <= w_seq_pc;
        end
    end

    assign pc          = r_pc;
    assign redirect    = r_redirect;
    assign sp          = r_sp;
    assign fault       = r_fault;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule
`default_nettype wire
